// File: rtl/pixel_loader.sv
// Serial 8-bit pixel loader for the MLP classifier: converts unsigned grayscale
// to non-negative signed values, packs a full frame, and flags it ready after a settle delay.

module pixel_slot #(
   parameter int RES = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           we,
   input  logic [RES-1:0] din,
   output logic [RES-1:0] q
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  q <= '0;
      else if (we) q <= din;
   end
endmodule

module pixel_loader #(
   parameter int PIXELS        = 784,
   parameter int RESOLUTION    = 8,
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 10
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         abort,
   input  logic [RESOLUTION-1:0]        pix_in,
   input  logic                         pix_valid,
   output logic                         pix_ready,
   output logic [RESOLUTION*PIXELS-1:0] pixels,
   output logic [CNT_W-1:0]             pix_count,
   output logic                         busy,
   output logic                         frame_ready
);
   typedef enum logic [1:0] {IDLE, LOAD, SETTLE, READY} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PIXELS - 1);

   state_t                               state;
   logic [7:0]                           settle;
   logic                                 wr_en;
   logic [RESOLUTION-1:0]                pix_conv;
   logic [PIXELS-1:0][RESOLUTION-1:0]    slot_q;

   // Logical shift keeps the MSB clear, so the signed result is always 0..127.
   assign pix_conv = RESOLUTION'(pix_in >> 1);
   assign wr_en    = pix_ready & pix_valid & ~abort;
   assign pixels   = slot_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pix_ready   <= 1'b0;
         busy        <= 1'b0;
         frame_ready <= 1'b0;
         pix_count   <= '0;
         settle      <= '0;
      end else if (abort) begin
         state       <= IDLE;
         pix_ready   <= 1'b0;
         busy        <= 1'b0;
         frame_ready <= 1'b0;
         pix_count   <= '0;
         settle      <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state     <= LOAD;
               pix_ready <= 1'b1;
               busy      <= 1'b1;
               pix_count <= '0;
            end
            LOAD: if (pix_valid) begin
               pix_count <= pix_count + 1'b1;
               if (pix_count == LAST) begin
                  state     <= SETTLE;
                  pix_ready <= 1'b0;
                  settle    <= 8'(SETTLE_CYCLES);
               end
            end
            SETTLE: begin
               if (settle == 8'd1) begin
                  state       <= READY;
                  busy        <= 1'b0;
                  frame_ready <= 1'b1;
               end else begin
                  settle <= settle - 8'd1;
               end
            end
            READY: if (start) begin
               state       <= LOAD;
               frame_ready <= 1'b0;
               pix_ready   <= 1'b1;
               busy        <= 1'b1;
               pix_count   <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // One register per pixel; only the slot addressed by pix_count is enabled.
   for (genvar k = 0; k < PIXELS; k++) begin : g_slot
      pixel_slot #(.RES(RESOLUTION)) u_slot (
         .clk   (clk),
         .reset (reset),
         .we    (wr_en && (pix_count == CNT_W'(k))),
         .din   (pix_conv),
         .q     (slot_q[k])
      );
   end
endmodule

// File: tb/tb_pixel_loader.sv
// Directed/random bench for pixel_loader against a timeline-based reference model.

module tb_pixel_loader;
   localparam int NPIX   = 784;
   localparam int SETTLE = 4;

   logic              clk = 1'b0;
   logic              reset, start, abort, pix_valid;
   logic [7:0]        pix_in;
   logic              pix_ready, busy, frame_ready;
   logic [NPIX*8-1:0] pixels;
   logic [9:0]        pix_count;

   pixel_loader dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pixels(pixels), .pix_count(pix_count), .busy(busy),
      .frame_ready(frame_ready)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: frame progress as counts and edge timestamps
   logic [7:0] m_slot [NPIX];
   bit         m_loading;
   int         m_cnt;
   int         m_done;     // edge at which frame_ready is due, -1 if none
   int         ecnt;
   int         last_xfer;

   function automatic bit m_busy();
      return m_loading || (m_done >= 0 && ecnt < m_done);
   endfunction
   function automatic bit m_ready();
      return m_done >= 0 && ecnt >= m_done;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, ecnt);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NPIX; i++) m_slot[i] = 8'h00;
      m_loading = 0; m_cnt = 0; m_done = -1;
   endtask

   task automatic check_outputs();
      chk("pix_ready",   32'(pix_ready),   32'(m_loading));
      chk("busy",        32'(busy),        32'(m_busy()));
      chk("frame_ready", 32'(frame_ready), 32'(m_ready()));
      chk("pix_count",   32'(pix_count),   32'(m_cnt));
   endtask

   task automatic check_slots(input string tag);
      for (int i = 0; i < NPIX; i++)
         chk(tag, 32'(pixels[i*8 +: 8]), 32'(m_slot[i]));
   endtask

   // One clock: model applies the spec rules to the inputs present at the edge
   task automatic tick();
      bit busy_pre;
      @(posedge clk);
      busy_pre = m_busy();
      ecnt++;
      if (abort) begin
         m_loading = 0; m_cnt = 0; m_done = -1;
      end else if (start && !busy_pre) begin
         m_loading = 1; m_cnt = 0; m_done = -1;
      end else if (m_loading && pix_valid) begin
         m_slot[m_cnt] = pix_in >> 1;
         m_cnt++;
         last_xfer = ecnt;
         if (m_cnt == NPIX) begin
            m_loading = 0;
            m_done = ecnt + SETTLE;
         end
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!frame_ready && n < 40) begin tick(); n++; end
      chk({tag, "_ready_reached"}, 32'(frame_ready), 32'd1);
      chk({tag, "_ready_delay"}, 32'(ecnt - last_xfer), 32'(SETTLE));
   endtask

   // Stream until the model holds 'upto' pixels; mode 0 = k mod 256 gap-free,
   // 1 = toggling valid w/ random data, 2 = all 0xFF, 3 = random with random gaps
   task automatic stream(input int mode, input int upto, input int start_at);
      int n = 0;
      int cyc = 0;
      while (m_cnt < upto && n < 4000) begin
         start = (start_at >= 0 && m_cnt == start_at);
         case (mode)
            0: begin pix_valid = 1; pix_in = 8'(m_cnt); end
            1: begin pix_valid = ~cyc[0]; pix_in = 8'($urandom); end
            2: begin pix_valid = 1; pix_in = 8'hFF; end
            default: begin pix_valid = ($urandom_range(0, 3) != 0); pix_in = 8'($urandom); end
         endcase
         tick();
         cyc++; n++;
      end
      start = 0; pix_valid = 0;
      chk("stream_bound", 32'(m_cnt >= upto), 32'd1);
   endtask

   task automatic pulse_start();
      start = 1; tick(); start = 0;
   endtask

   initial begin
      reset = 0; start = 0; abort = 0; pix_valid = 0; pix_in = 8'h00;
      ecnt = 0; last_xfer = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs();
      chk("rst_pixels_zero", 32'(pixels == '0), 32'd1);
      reset = 1;
      tick(); tick();

      // Gap-free frame with ramp data
      pulse_start();
      stream(0, NPIX, -1);
      chk("count_784", 32'(pix_count), 32'd784);
      wait_ready("gapfree");
      chk("slot255", 32'(pixels[255*8 +: 8]), 32'h7F);
      chk("slot256", 32'(pixels[256*8 +: 8]), 32'h00);
      chk("slot128", 32'(pixels[128*8 +: 8]), 32'h40);
      check_slots("gapfree_slot");
      repeat (3) tick();
      chk("ready_holds", 32'(frame_ready), 32'd1);

      // Bubbly frame; start at pixel 100 and during SETTLE must be ignored
      pulse_start();
      stream(1, NPIX, 100);
      start = 1; tick(); start = 0;
      wait_ready("bubbly");
      check_slots("bubbly_slot");

      // Abort at 400 together with a valid pixel that would change slot 400
      pulse_start();
      stream(3, 400, -1);
      abort = 1; pix_valid = 1; start = 1;
      pix_in = {~m_slot[400][6:0], 1'b0};
      tick();
      abort = 0; pix_valid = 0; start = 0;
      chk("abort_count", 32'(pix_count), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      check_slots("abort_slot");
      tick();

      // Random frame, then back-to-back all-0xFF frame from READY
      pulse_start();
      stream(3, NPIX, -1);
      wait_ready("rand");
      check_slots("rand_slot");
      pulse_start();
      chk("b2b_ready_fell", 32'(frame_ready), 32'd0);
      stream(2, NPIX, -1);
      wait_ready("b2b");
      check_slots("b2b_slot");

      // Async reset in the middle of SETTLE
      pulse_start();
      stream(3, NPIX, -1);
      tick(); tick();
      chk("settle_busy", 32'(busy), 32'd1);
      #2 reset = 0;
      #1;
      model_reset();
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_pix_ready", 32'(pix_ready), 32'd0);
      chk("arst_frame_ready", 32'(frame_ready), 32'd0);
      chk("arst_count", 32'(pix_count), 32'd0);
      chk("arst_pixels", 32'(pixels == '0), 32'd1);
      @(negedge clk);
      reset = 1;
      repeat (5) tick();
      chk("idle_after_rst", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
